bcd_counter_display: RTL and testbench

- Parametrised successor to the single-digit 163-style counter with its 7-segment driver.
- An N-digit BCD counter with:
  - programmable terminal value
  - up/down mode
  - 163-style clear/load/enable/ripple-carry semantics
  - on-chip count prescaler
  - time-multiplexed 7-segment display with optional leading-zero blanking
- Entirely synchronous to clk_50mhz. The prescaler produces a one-cycle clock-enable, never a derived clock.

---
 rtl/bcd_counter_display_if.sv | 31 +++
 rtl/bcd_counter_display.sv | 176 +++++++++++++++++
 tb/tb_bcd_counter_display.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_counter_display_if.sv
// Control and status bundle for the BCD counter / 7-segment display block.
// The master side drives the count controls and the display controls.
// The slave side, which is the counter itself, returns the count, carry, tick and display drive.
interface bcd_counter_display_if #(
  parameter int unsigned DIGITS = 3
);
  logic                  clrn;
  logic                  ldn;
  logic                  enp;
  logic                  ent;
  logic                  up_dn;
  logic                  lz_blank;
  logic                  n_en;
  logic [4*DIGITS-1:0]   data_in;
  logic [4*DIGITS-1:0]   max_bcd;
  logic [4*DIGITS-1:0]   q_out;
  logic                  rco;
  logic                  tick_o;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     sel;

  modport master (
    output clrn, ldn, enp, ent, up_dn, lz_blank, n_en, data_in, max_bcd,
    input  q_out, rco, tick_o, seg, sel
  );

  modport slave (
    input  clrn, ldn, enp, ent, up_dn, lz_blank, n_en, data_in, max_bcd,
    output q_out, rco, tick_o, seg, sel
  );
endinterface

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with 163-style clear/load/enable/carry, a count
// prescaler that produces a one-cycle clock enable, and a time-multiplexed
// 7-segment display with optional leading-zero blanking.
module bcd_counter_display #(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned CLK_DIV  = 50000000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                    clk_50mhz,
  input logic                    rst,
  bcd_counter_display_if.slave   bus
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};

  logic [PW-1:0]     pre_q;
  logic              tick_q;
  logic [W-1:0]      q_q, q_d;
  logic [W-1:0]      eff_max, load_val, inc_val, dec_val;
  logic              max_ok;
  logic [SW-1:0]     scan_q;
  logic [IW-1:0]     idx_q;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        cur_dig;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3f;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5b;
      4'd3:    seg_decode = 7'h4f;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6d;
      4'd6:    seg_decode = 7'h7d;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7f;
      4'd9:    seg_decode = 7'h6f;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Prescaler: wraps every CLK_DIV cycles, registered one-cycle tick on wrap.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (pre_q == PRE_LAST);
      pre_q  <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
  end

  // Terminal value, sanitised load value, and BCD increment/decrement of the count.
  always_comb begin
    logic [3:0] dig;
    logic       carry;
    logic       borrow;
    max_ok   = 1'b1;
    load_val = '0;
    inc_val  = '0;
    dec_val  = '0;
    dig      = '0;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.max_bcd[4*i +: 4] > 4'd9) max_ok = 1'b0;
      load_val[4*i +: 4] = (bus.data_in[4*i +: 4] > 4'd9) ? 4'd0 : bus.data_in[4*i +: 4];
      dig = q_q[4*i +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end else begin
        inc_val[4*i +: 4] = dig;
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        dec_val[4*i +: 4] = dig;
      end
    end
    // An invalid terminal value falls back to the full-scale count.
    eff_max = max_ok ? bus.max_bcd : ALL_NINES;
  end

  // Count next state: tick-qualified clear > load > count, else hold.
  always_comb begin
    q_d = q_q;
    if (tick_q) begin
      if (!bus.clrn) begin
        q_d = '0;
      end else if (!bus.ldn) begin
        q_d = load_val;
      end else if (bus.enp && bus.ent) begin
        if (bus.up_dn) begin
          q_d = (q_q >= eff_max) ? '0 : inc_val;
        end else begin
          q_d = ((q_q == '0) || (q_q > eff_max)) ? eff_max : dec_val;
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  // Scan timer and digit index.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

  // Leading-zero mask and next display drive for the current digit.
  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      lead     = lead & (q_q[4*i +: 4] == 4'd0);
      blank[i] = lead && (i != 0);
    end
    cur_dig = q_q[4*int'(idx_q) +: 4];
    sel_d   = '1;
    seg_d   = '0;
    if (!bus.n_en && !(bus.lz_blank && blank[idx_q])) begin
      sel_d[idx_q] = 1'b0;
      seg_d        = seg_decode(cur_dig);
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      sel_q <= '1;
      seg_q <= '0;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign bus.q_out  = q_q;
  assign bus.tick_o = tick_q;
  assign bus.sel    = sel_q;
  assign bus.seg    = seg_q;
  assign bus.rco    = bus.ent & (bus.up_dn ? (q_q >= eff_max) : (q_q == '0));

endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display: DIGITS=3, CLK_DIV=4, SCAN_DIV=2.
module tb_bcd_counter_display;

  logic clk;
  logic rst;

  bcd_counter_display_if #(.DIGITS(3)) bus ();

  bcd_counter_display #(
    .DIGITS  (3),
    .CLK_DIV (4),
    .SCAN_DIV(2)
  ) dut (
    .clk_50mhz(clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  typedef struct {
    logic        clrn;
    logic        ldn;
    logic        enp;
    logic        ent;
    logic        up_dn;
    logic [11:0] data_in;
    logic [11:0] max_bcd;
    logic [11:0] exp_q;
    logic        exp_rco;
  } vec_t;

  int tests;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, wait for the next tick (count must hold meanwhile), then check.
  task automatic apply(input vec_t v, input int idx);
    int          guard;
    logic [11:0] prev;
    bus.clrn    = v.clrn;
    bus.ldn     = v.ldn;
    bus.enp     = v.enp;
    bus.ent     = v.ent;
    bus.up_dn   = v.up_dn;
    bus.data_in = v.data_in;
    bus.max_bcd = v.max_bcd;
    prev  = bus.q_out;
    guard = 0;
    while (bus.tick_o !== 1'b1 && guard < 8) begin
      step();
      guard++;
      chk($sformatf("vec%0d hold", idx), 32'(bus.q_out), 32'(prev));
    end
    if (bus.tick_o !== 1'b1) begin
      chk($sformatf("vec%0d tick timeout", idx), 32'(bus.tick_o), 32'd1);
    end
    step();
    chk($sformatf("vec%0d q_out", idx), 32'(bus.q_out), 32'(v.exp_q));
    chk($sformatf("vec%0d rco", idx), 32'(bus.rco), 32'(v.exp_rco));
  endtask

  vec_t vecs[15];

  initial begin
    int   n0;
    int   n1;
    int   n2;
    logic [2:0] prev_sel;
    logic [6:0] exp_seg;
    vec_t v;

    //          clrn ldn enp ent up  data    max     exp_q   rco
    vecs[0]  = '{1, 0, 1, 1, 1, 12'h998, 12'h999, 12'h998, 0};
    vecs[1]  = '{1, 1, 1, 1, 1, 12'h000, 12'h999, 12'h999, 1};
    vecs[2]  = '{1, 1, 1, 1, 1, 12'h000, 12'h999, 12'h000, 0};
    vecs[3]  = '{1, 0, 1, 1, 0, 12'h001, 12'h059, 12'h001, 0};
    vecs[4]  = '{1, 1, 1, 1, 0, 12'h000, 12'h059, 12'h000, 1};
    vecs[5]  = '{1, 1, 1, 1, 0, 12'h000, 12'h059, 12'h059, 0};
    vecs[6]  = '{1, 1, 1, 1, 0, 12'h000, 12'h059, 12'h058, 0};
    vecs[7]  = '{1, 0, 1, 1, 0, 12'h070, 12'h059, 12'h070, 0};
    vecs[8]  = '{1, 1, 1, 1, 0, 12'h000, 12'h059, 12'h059, 0};
    vecs[9]  = '{0, 0, 1, 1, 1, 12'h123, 12'h999, 12'h000, 0};
    vecs[10] = '{1, 0, 1, 1, 1, 12'h0a5, 12'h999, 12'h005, 0};
    vecs[11] = '{1, 1, 0, 1, 1, 12'h000, 12'h005, 12'h005, 1};
    vecs[12] = '{1, 1, 1, 0, 1, 12'h000, 12'h005, 12'h005, 0};
    vecs[13] = '{1, 1, 1, 1, 1, 12'h000, 12'h0a5, 12'h006, 0};
    vecs[14] = '{1, 1, 1, 1, 1, 12'h000, 12'h999, 12'h007, 0};

    tests = 0;
    fails = 0;
    rst          = 1'b0;
    bus.clrn     = 1'b1;
    bus.ldn      = 1'b1;
    bus.enp      = 1'b1;
    bus.ent      = 1'b1;
    bus.up_dn    = 1'b1;
    bus.lz_blank = 1'b0;
    bus.n_en     = 1'b0;
    bus.data_in  = 12'h000;
    bus.max_bcd  = 12'h999;

    // Reset state.
    step();
    step();
    chk("reset q_out", 32'(bus.q_out), 32'h000);
    chk("reset tick_o", 32'(bus.tick_o), 32'd0);
    chk("reset sel", 32'(bus.sel), 32'h7);
    chk("reset seg", 32'(bus.seg), 32'h00);

    // Prescaler phase and first counts after release.
    rst = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("pre tick c%0d", c), 32'(bus.tick_o), 32'((c % 4) == 0));
      chk($sformatf("pre q c%0d", c), 32'(bus.q_out), 32'((c - 1) / 4));
    end

    // Counting, limits, priority and enables.
    for (int i = 0; i < 15; i++) apply(vecs[i], i);

    // Display with q_out=007, counting held.
    bus.enp      = 1'b0;
    bus.lz_blank = 1'b1;
    step();
    n0 = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.sel == 3'b110) begin
        n0++;
        chk("lz digit0 seg", 32'(bus.seg), 32'h07);
      end else begin
        chk("lz blanked", {22'd0, bus.sel, bus.seg}, {22'd0, 3'b111, 7'h00});
      end
    end
    chk("lz digit0 count", 32'(n0), 32'd4);

    bus.lz_blank = 1'b0;
    step();
    n0 = 0;
    n1 = 0;
    n2 = 0;
    prev_sel = bus.sel;
    for (int c = 0; c < 12; c++) begin
      step();
      exp_seg = 7'h3f;
      case (bus.sel)
        3'b110: begin n0++; exp_seg = 7'h07; end
        3'b101: n1++;
        3'b011: n2++;
        default: chk("nolz sel onehot", 32'(bus.sel), 32'h6);
      endcase
      chk("nolz seg", 32'(bus.seg), 32'(exp_seg));
      if (bus.sel != prev_sel) begin
        chk("scan order", 32'(bus.sel), 32'({prev_sel[1:0], prev_sel[2]}));
      end
      prev_sel = bus.sel;
    end
    chk("nolz digit0 count", 32'(n0), 32'd4);
    chk("nolz digit1 count", 32'(n1), 32'd4);
    chk("nolz digit2 count", 32'(n2), 32'd4);

    bus.n_en = 1'b1;
    step();
    for (int c = 0; c < 6; c++) begin
      step();
      chk("n_en blank", {22'd0, bus.sel, bus.seg}, {22'd0, 3'b111, 7'h00});
    end
    bus.n_en = 1'b0;

    // Load 123, then reset mid-period.
    v = '{1, 0, 0, 0, 1, 12'h123, 12'h999, 12'h123, 0};
    apply(v, 15);
    bus.ldn = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst q_out", 32'(bus.q_out), 32'h000);
    chk("midrst sel", 32'(bus.sel), 32'h7);
    chk("midrst seg", 32'(bus.seg), 32'h00);
    chk("midrst tick_o", 32'(bus.tick_o), 32'd0);
    step();
    step();
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("post-rst tick c%0d", c), 32'(bus.tick_o), 32'(c == 4));
    end
    chk("post-rst q_out", 32'(bus.q_out), 32'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
